scaler_h_ctrl: RTL and testbench

- Front-end sequencer and configurator for the horizontal scaler (scaler_h).
- Converts raw level-style video timing into the scaler's strobe timing: a one-cycle hs pulse at each line start, plus registered di/de/vs.
- Double-buffers the scale step so the scaler sees a new value only at a frame boundary.
- Monitors scaler output per line and flags overrun when a new input line starts before the previous line's output completes.

---
 rtl/scaler_h_pkg.sv | 9 +
 rtl/scaler_h_edge.sv | 26 ++
 rtl/scaler_h_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_scaler_h_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_h_pkg.sv
// Shared types and defaults for the horizontal scaler front-end.
package scaler_h_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, GAP} ctrl_state_t;

    localparam int PIXEL_STEP_DEF = 4096;
    localparam int STEP_MIN_DEF   = 1024;

endpackage

// File: rtl/scaler_h_edge.sv
// Registered rise/fall detector: edges compare the live input with its previous-cycle copy.
module scaler_h_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q, sig_d;

    always_comb begin
        sig_d = sig_i;
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= RST_VAL;
        else     sig_q <= sig_d;
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/scaler_h_ctrl.sv
// Timing sequencer, frame-synchronous step double-buffer and output overrun monitor for scaler_h.
// Define SCALER_H_CTRL_STAT_EN to add per-line/per-frame width and line-count statistics.
module scaler_h_ctrl
    import scaler_h_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int STEP_WIDTH  = 16,
    parameter int PIXEL_STEP  = PIXEL_STEP_DEF,
    parameter int STEP_MIN    = STEP_MIN_DEF,
    parameter int CNT_WIDTH   = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STEP_WIDTH-1:0]  cfg_step_i,
    input  logic                   cfg_wr_i,
    output logic                   cfg_ack_o,
    output logic                   cfg_err_o,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] sc_di_o,
    output logic                   sc_de_o,
    output logic                   sc_hs_o,
    output logic                   sc_vs_o,
    output logic [STEP_WIDTH-1:0]  sc_step_o,
    input  logic                   sc_de_i,
    input  logic                   sc_hs_i,
    output logic                   line_overrun_o,
    output logic                   busy_o
`ifdef SCALER_H_CTRL_STAT_EN
    ,
    output logic [CNT_WIDTH-1:0]   stat_in_w_o,
    output logic [CNT_WIDTH-1:0]   stat_out_w_o,
    output logic [CNT_WIDTH-1:0]   stat_lines_o
`endif
);

    localparam logic [STEP_WIDTH-1:0] STEP_MIN_W  = STEP_WIDTH'(STEP_MIN);
    localparam logic [STEP_WIDTH-1:0] STEP_UNITY  = STEP_WIDTH'(PIXEL_STEP);

    if (STEP_MIN < 1 || CNT_WIDTH < 2) begin : g_bad_cfg
        $error("scaler_h_ctrl: STEP_MIN must be >= 1 and CNT_WIDTH >= 2");
    end

    logic hs_rise, hs_fall, vs_rise, vs_fall, sde_rise, sde_fall;

    // vs detector resets high so a reset inside an active frame never fakes a frame start.
    scaler_h_edge #(.RST_VAL(1'b0)) u_hs_edge  (.clk(clk), .rst(rst), .sig_i(hs_i),    .rise_o(hs_rise),  .fall_o(hs_fall));
    scaler_h_edge #(.RST_VAL(1'b1)) u_vs_edge  (.clk(clk), .rst(rst), .sig_i(vs_i),    .rise_o(vs_rise),  .fall_o(vs_fall));
    scaler_h_edge #(.RST_VAL(1'b0)) u_sde_edge (.clk(clk), .rst(rst), .sig_i(sc_de_i), .rise_o(sde_rise), .fall_o(sde_fall));

    ctrl_state_t             state_q, state_d;
    logic [PIXEL_WIDTH-1:0]  sc_di_q, sc_di_d;
    logic                    sc_de_q, sc_de_d, sc_hs_q, sc_hs_d, sc_vs_q, sc_vs_d;
    logic [STEP_WIDTH-1:0]   sc_step_q, sc_step_d, shadow_q, shadow_d;
    logic                    ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic                    overrun_q, overrun_d, pending_q, pending_d, seen_q, seen_d;
    logic                    step_ok;

    always_comb begin
        state_d = state_q;
        if (vs_fall) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (vs_rise) state_d = WAIT_LINE;
                WAIT_LINE: if (hs_fall) state_d = ACTIVE;
                ACTIVE:    if (hs_rise) state_d = GAP;
                GAP:       if (hs_fall) state_d = ACTIVE;
                default:   state_d = IDLE;
            endcase
        end

        step_ok   = (cfg_step_i >= STEP_MIN_W) && (cfg_step_i != '0);
        shadow_d  = (cfg_wr_i && step_ok) ? cfg_step_i : shadow_q;
        ack_d     = cfg_wr_i && step_ok;
        err_d     = cfg_wr_i && !step_ok;
        // Shadow_q is the pre-write value here, so a same-cycle write lands next frame.
        sc_step_d = (state_q == IDLE && vs_rise) ? shadow_q : sc_step_q;

        sc_di_d = di_i;
        sc_de_d = de_i && (state_q != IDLE);
        sc_hs_d = hs_fall && (state_q != IDLE) && !vs_fall;
        sc_vs_d = ~vs_i;
        busy_d  = (state_d != IDLE);

        pending_d = pending_q;
        seen_d    = seen_q | sde_rise;
        overrun_d = overrun_q;
        if (sde_fall) pending_d = 1'b0;
        // A pending line with no scaler output yet is treated as empty, not overrun.
        if (sc_hs_q) begin
            if (pending_q && seen_q) overrun_d = 1'b1;
            pending_d = 1'b1;
            seen_d    = sde_rise;
        end
        if (cfg_wr_i) overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sc_di_q   <= '0;
            sc_de_q   <= 1'b0;
            sc_hs_q   <= 1'b0;
            sc_vs_q   <= 1'b1;
            sc_step_q <= STEP_UNITY;
            shadow_q  <= STEP_UNITY;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            pending_q <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_di_q   <= sc_di_d;
            sc_de_q   <= sc_de_d;
            sc_hs_q   <= sc_hs_d;
            sc_vs_q   <= sc_vs_d;
            sc_step_q <= sc_step_d;
            shadow_q  <= shadow_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            pending_q <= pending_d;
            seen_q    <= seen_d;
        end
    end

    assign sc_di_o        = sc_di_q;
    assign sc_de_o        = sc_de_q;
    assign sc_hs_o        = sc_hs_q;
    assign sc_vs_o        = sc_vs_q;
    assign sc_step_o      = sc_step_q;
    assign cfg_ack_o      = ack_q;
    assign cfg_err_o      = err_q;
    assign busy_o         = busy_q;
    assign line_overrun_o = overrun_q;

`ifdef SCALER_H_CTRL_STAT_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] stat_in_q, stat_in_d, stat_out_q, stat_out_d, stat_lines_q, stat_lines_d;

    always_comb begin
        in_cnt_d  = sat_inc(in_cnt_q, sc_de_d);
        stat_in_d = stat_in_q;
        if (sc_hs_d) in_cnt_d = sat_inc('0, sc_de_d);
        if (hs_rise && state_q == ACTIVE) begin
            stat_in_d = in_cnt_q;
            in_cnt_d  = '0;
        end

        out_cnt_d  = sat_inc(out_cnt_q, sc_de_i);
        stat_out_d = stat_out_q;
        if (sde_fall) begin
            stat_out_d = out_cnt_q;
            out_cnt_d  = '0;
        end

        line_cnt_d   = sat_inc(line_cnt_q, sc_hs_d);
        stat_lines_d = stat_lines_q;
        if (vs_fall) begin
            stat_lines_d = line_cnt_q;
            line_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            line_cnt_q   <= '0;
            stat_in_q    <= '0;
            stat_out_q   <= '0;
            stat_lines_q <= '0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            line_cnt_q   <= line_cnt_d;
            stat_in_q    <= stat_in_d;
            stat_out_q   <= stat_out_d;
            stat_lines_q <= stat_lines_d;
        end
    end

    assign stat_in_w_o  = stat_in_q;
    assign stat_out_w_o = stat_out_q;
    assign stat_lines_o = stat_lines_q;
`endif

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Directed bench for scaler_h_ctrl: step double-buffering, line timing, overrun and mid-line reset.
module tb_scaler_h_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_step_i;
    logic        cfg_wr_i;
    logic        cfg_ack_o, cfg_err_o;
    logic [7:0]  di_i;
    logic        de_i, hs_i, vs_i;
    logic [7:0]  sc_di_o;
    logic        sc_de_o, sc_hs_o, sc_vs_o;
    logic [15:0] sc_step_o;
    logic        sc_de_i;
    logic        sc_hs_i;
    logic        line_overrun_o, busy_o;
`ifdef SCALER_H_CTRL_STAT_EN
    logic [12:0] stat_in_w_o, stat_out_w_o, stat_lines_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int de_cnt = 0;
    int sc_cnt = 0;
    bit scaler_en = 1'b0;

    always #5 clk = ~clk;

    scaler_h_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_step_i(cfg_step_i), .cfg_wr_i(cfg_wr_i), .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .sc_di_o(sc_di_o), .sc_de_o(sc_de_o), .sc_hs_o(sc_hs_o), .sc_vs_o(sc_vs_o),
        .sc_step_o(sc_step_o), .sc_de_i(sc_de_i), .sc_hs_i(sc_hs_i),
        .line_overrun_o(line_overrun_o), .busy_o(busy_o)
`ifdef SCALER_H_CTRL_STAT_EN
        , .stat_in_w_o(stat_in_w_o), .stat_out_w_o(stat_out_w_o), .stat_lines_o(stat_lines_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] step);
        cfg_step_i = step;
        cfg_wr_i   = 1'b1;
        cyc();
        cfg_wr_i   = 1'b0;
    endtask

    task automatic drive_line(input int px, input int gap, input bit do_chk);
        logic [7:0] exp_di;
        for (int i = 0; i < px; i++) begin
            exp_di = 8'(i * 7 + 3);
            hs_i = 1'b0;
            de_i = 1'b1;
            di_i = exp_di;
            cyc();
            if (do_chk) begin
                chk("sc_di_delay", {24'd0, sc_di_o}, {24'd0, exp_di});
                chk("sc_de_fwd", {31'd0, sc_de_o}, 32'd1);
                if (i == 0) chk("hs_pulse_first", {31'd0, sc_hs_o}, 32'd1);
                if (i == 1) chk("hs_pulse_single", {31'd0, sc_hs_o}, 32'd0);
            end
        end
        hs_i = 1'b1;
        de_i = 1'b0;
        di_i = 8'd0;
        repeat (gap) cyc();
    endtask

    // Output-side counters for the forwarded strobes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sc_hs_o) hs_cnt++;
            if (sc_de_o) de_cnt++;
        end
    end

    // Scaler model: output de high for 48 clk after each line-start pulse.
    initial begin
        sc_de_i = 1'b0;
        sc_hs_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (scaler_en && sc_hs_o) sc_cnt = 48;
            sc_de_i = (sc_cnt != 0);
            if (sc_cnt != 0) sc_cnt--;
        end
    end

    initial begin
        rst = 1'b1; cfg_step_i = '0; cfg_wr_i = 1'b0;
        di_i = '0; de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
        repeat (3) cyc();
        chk("rst_sc_vs", {31'd0, sc_vs_o}, 32'd1);
        chk("rst_step", {16'd0, sc_step_o}, 32'd4096);
        chk("rst_sc_hs", {31'd0, sc_hs_o}, 32'd0);
        chk("rst_sc_de", {31'd0, sc_de_o}, 32'd0);
        chk("rst_sc_di", {24'd0, sc_di_o}, 32'd0);
        chk("rst_ack", {31'd0, cfg_ack_o}, 32'd0);
        chk("rst_err", {31'd0, cfg_err_o}, 32'd0);
        chk("rst_ovr", {31'd0, line_overrun_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // Frame A: mid-frame write is held back; 4 lines x 24 px.
        vs_i = 1'b1;
        cyc();
        chk("a_busy", {31'd0, busy_o}, 32'd1);
        chk("a_sc_vs", {31'd0, sc_vs_o}, 32'd0);
        cyc();
        cfg_write(16'd8192);
        chk("a_ack", {31'd0, cfg_ack_o}, 32'd1);
        chk("a_no_err", {31'd0, cfg_err_o}, 32'd0);
        chk("a_step_held", {16'd0, sc_step_o}, 32'd4096);
        cyc();
        chk("a_ack_pulse", {31'd0, cfg_ack_o}, 32'd0);
        hs_cnt = 0; de_cnt = 0;
        for (int l = 0; l < 4; l++) drive_line(24, 10, 1'b1);
        vs_i = 1'b0;
        repeat (3) cyc();
        chk("a_hs_count", hs_cnt, 32'd4);
        chk("a_de_count", de_cnt, 32'd96);
        chk("a_step_idle", {16'd0, sc_step_o}, 32'd4096);
        chk("a_idle", {31'd0, busy_o}, 32'd0);
        chk("a_ovr", {31'd0, line_overrun_o}, 32'd0);

        // Frame B: new step applies; rejected and boundary writes; overrun with 10 clk gap.
        vs_i = 1'b1;
        cyc();
        chk("b_step_new", {16'd0, sc_step_o}, 32'd8192);
        cfg_write(16'd512);
        chk("b_err_512", {31'd0, cfg_err_o}, 32'd1);
        chk("b_noack_512", {31'd0, cfg_ack_o}, 32'd0);
        cfg_write(16'd1023);
        chk("b_err_1023", {31'd0, cfg_err_o}, 32'd1);
        cfg_write(16'd1024);
        chk("b_ack_1024", {31'd0, cfg_ack_o}, 32'd1);
        chk("b_noerr_1024", {31'd0, cfg_err_o}, 32'd0);
        chk("b_step_hold", {16'd0, sc_step_o}, 32'd8192);
        scaler_en = 1'b1;
        drive_line(24, 10, 1'b0);
        chk("b_ovr_line1", {31'd0, line_overrun_o}, 32'd0);
        drive_line(24, 10, 1'b0);
        chk("b_ovr_line2", {31'd0, line_overrun_o}, 32'd1);
        drive_line(24, 10, 1'b0);
        vs_i = 1'b0;
        repeat (60) cyc();
        chk("b_ovr_sticky", {31'd0, line_overrun_o}, 32'd1);
        cfg_write(16'd4096);
        chk("b_ovr_clear", {31'd0, line_overrun_o}, 32'd0);

        // Frame C: write on the vs edge takes the old shadow; empty outputs; 60 clk gap.
        vs_i = 1'b1;
        cfg_step_i = 16'd2048;
        cfg_wr_i = 1'b1;
        cyc();
        cfg_wr_i = 1'b0;
        chk("c_step_old", {16'd0, sc_step_o}, 32'd4096);
        chk("c_ack_edge", {31'd0, cfg_ack_o}, 32'd1);
        scaler_en = 1'b0;
        drive_line(24, 10, 1'b0);
        drive_line(24, 10, 1'b0);
        chk("c_ovr_noout", {31'd0, line_overrun_o}, 32'd0);
        scaler_en = 1'b1;
        drive_line(24, 60, 1'b0);
        drive_line(24, 60, 1'b0);
        vs_i = 1'b0;
        repeat (60) cyc();
        chk("c_ovr_gap60", {31'd0, line_overrun_o}, 32'd0);
`ifdef SCALER_H_CTRL_STAT_EN
        chk("c_stat_in_w", {19'd0, stat_in_w_o}, 32'd24);
        chk("c_stat_out_w", {19'd0, stat_out_w_o}, 32'd48);
        chk("c_stat_lines", {19'd0, stat_lines_o}, 32'd4);
`endif
        scaler_en = 1'b0;

        // Frame D: reset during line 2; the remainder of the frame is dropped.
        vs_i = 1'b1;
        cyc();
        chk("d_step_next", {16'd0, sc_step_o}, 32'd2048);
        drive_line(24, 10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            hs_i = 1'b0; de_i = 1'b1; di_i = 8'(i + 100);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("d_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("d_rst_sc_de", {31'd0, sc_de_o}, 32'd0);
        chk("d_rst_sc_di", {24'd0, sc_di_o}, 32'd0);
        chk("d_rst_sc_vs", {31'd0, sc_vs_o}, 32'd1);
        chk("d_rst_step", {16'd0, sc_step_o}, 32'd4096);
        hs_cnt = 0; de_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            hs_i = 1'b0; de_i = 1'b1;
            cyc();
        end
        hs_i = 1'b1; de_i = 1'b0;
        repeat (10) cyc();
        drive_line(24, 10, 1'b0);
        vs_i = 1'b0;
        repeat (3) cyc();
        chk("d_hs_dropped", hs_cnt, 32'd0);
        chk("d_de_dropped", de_cnt, 32'd0);

        // Frame E: normal operation after the reset.
        hs_cnt = 0; de_cnt = 0;
        vs_i = 1'b1;
        cyc();
        chk("e_busy", {31'd0, busy_o}, 32'd1);
        chk("e_step", {16'd0, sc_step_o}, 32'd4096);
        drive_line(24, 10, 1'b1);
        vs_i = 1'b0;
        repeat (3) cyc();
        chk("e_hs_count", hs_cnt, 32'd1);
        chk("e_de_count", de_cnt, 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
